// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage, sitting between the IF/ID and ID/EX registers.
//   Inputs : clk, reset (async, active-high), clr (sync ID/EX flush),
//            InstrD/PCD/PCplus4D fetch bundle, RegWriteW/RdW/ResultW write-back port.
//   Outputs: Rs1D/Rs2D (combinational, to the hazard unit) and the registered
//            ID/EX bundle (*E) feeding Execute.
// Holds the 32x32 register file (x0 hard-wired to zero, write-through on read).
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCplus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCplus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        JalrE,
  output logic        ALUSrcBE,
  output logic        IllegalE,
  output logic [1:0]  ResultSrcE,
  output logic [1:0]  ALUSrcAE,
  output logic [3:0]  ALUControlE,
  output logic [2:0]  Funct3E
);

  typedef enum logic [6:0] {
    OP_R     = 7'b0110011,
    OP_IALU  = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_BR    = 7'b1100011,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
    ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9
  } alu_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_sel_e;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        regw, memw, br, jmp, jalr, srcb, ill;
    logic [1:0]  rsrc, srca;
    logic [3:0]  alu;
    logic [2:0]  f3;
  } idex_t;

  // alt selects SUB/SRA; callers decide when funct7[5] is allowed to count.
  function automatic alu_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [31:0] r_regs [32];
  idex_t       r_idex;
  idex_t       w_next;
  imm_sel_e    w_imm_sel;
  logic [31:0] w_imm;
  logic [31:0] w_rd1, w_rd2;

  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (RegWriteW && RdW != 5'd0) begin
      r_regs[RdW] <= ResultW;
    end
  end

  always_comb begin
    w_rd1 = r_regs[Rs1D];
    w_rd2 = r_regs[Rs2D];
    if (Rs1D == 5'd0) w_rd1 = '0;
    else if (RegWriteW && RdW == Rs1D) w_rd1 = ResultW;
    if (Rs2D == 5'd0) w_rd2 = '0;
    else if (RegWriteW && RdW == Rs2D) w_rd2 = ResultW;
  end

  always_comb begin
    case (w_imm_sel)
      IMM_I:   w_imm = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   w_imm = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   w_imm = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J:   w_imm = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      IMM_U:   w_imm = {InstrD[31:12], 12'b0};
      default: w_imm = '0;
    endcase
  end

  always_comb begin
    w_next     = '0;
    w_imm_sel  = IMM_NONE;
    w_next.rd1 = w_rd1;
    w_next.rd2 = w_rd2;
    w_next.pc  = PCD;
    w_next.pc4 = PCplus4D;
    w_next.rs1 = Rs1D;
    w_next.rs2 = Rs2D;
    w_next.rd  = InstrD[11:7];
    w_next.f3  = InstrD[14:12];
    w_next.alu = ALU_ADD;
    case (InstrD[6:0])
      OP_R: begin
        w_next.regw = 1'b1;
        w_next.alu  = alu_from_f3(InstrD[14:12], InstrD[30]);
      end
      OP_IALU: begin
        w_next.regw = 1'b1;
        w_next.srcb = 1'b1;
        w_imm_sel   = IMM_I;
        // Bit 30 is immediate data except for SRAI.
        w_next.alu  = alu_from_f3(InstrD[14:12], InstrD[30] && InstrD[14:12] == 3'b101);
      end
      OP_LOAD: begin
        w_next.regw = 1'b1;
        w_next.rsrc = 2'b01;
        w_next.srcb = 1'b1;
        w_imm_sel   = IMM_I;
      end
      OP_STORE: begin
        w_next.memw = 1'b1;
        w_next.srcb = 1'b1;
        w_imm_sel   = IMM_S;
      end
      OP_BR: begin
        w_next.br  = 1'b1;
        w_next.alu = ALU_SUB;
        w_imm_sel  = IMM_B;
      end
      OP_JAL: begin
        w_next.regw = 1'b1;
        w_next.jmp  = 1'b1;
        w_next.rsrc = 2'b10;
        w_imm_sel   = IMM_J;
      end
      OP_JALR: begin
        w_next.regw = 1'b1;
        w_next.jmp  = 1'b1;
        w_next.jalr = 1'b1;
        w_next.rsrc = 2'b10;
        w_next.srcb = 1'b1;
        w_imm_sel   = IMM_I;
      end
      OP_LUI: begin
        w_next.regw = 1'b1;
        w_next.srca = 2'b10;
        w_next.srcb = 1'b1;
        w_imm_sel   = IMM_U;
      end
      OP_AUIPC: begin
        w_next.regw = 1'b1;
        w_next.srca = 2'b01;
        w_next.srcb = 1'b1;
        w_imm_sel   = IMM_U;
      end
      default: begin
        // The all-zero word is the IF/ID bubble, not an illegal instruction.
        w_next.ill = (InstrD != '0);
      end
    endcase
    w_next.imm = w_imm;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    r_idex <= '0;
    else if (clr) r_idex <= '0;
    else          r_idex <= w_next;
  end

  assign RD1E        = r_idex.rd1;
  assign RD2E        = r_idex.rd2;
  assign ImmExtE     = r_idex.imm;
  assign PCE         = r_idex.pc;
  assign PCplus4E    = r_idex.pc4;
  assign Rs1E        = r_idex.rs1;
  assign Rs2E        = r_idex.rs2;
  assign RdE         = r_idex.rd;
  assign RegWriteE   = r_idex.regw;
  assign MemWriteE   = r_idex.memw;
  assign BranchE     = r_idex.br;
  assign JumpE       = r_idex.jmp;
  assign JalrE       = r_idex.jalr;
  assign ALUSrcBE    = r_idex.srcb;
  assign IllegalE    = r_idex.ill;
  assign ResultSrcE  = r_idex.rsrc;
  assign ALUSrcAE    = r_idex.srca;
  assign ALUControlE = r_idex.alu;
  assign Funct3E     = r_idex.f3;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, clr;
  logic [31:0] InstrD, PCD, PCplus4D;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [4:0]  Rs1D, Rs2D;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCplus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcBE, IllegalE;
  logic [1:0]  ResultSrcE, ALUSrcAE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;

  decode_stage dut (
    .clk(clk), .reset(reset), .clr(clr),
    .InstrD(InstrD), .PCD(PCD), .PCplus4D(PCplus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCplus4E(PCplus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .JalrE(JalrE), .ALUSrcBE(ALUSrcBE), .IllegalE(IllegalE),
    .ResultSrcE(ResultSrcE), .ALUSrcAE(ALUSrcAE), .ALUControlE(ALUControlE),
    .Funct3E(Funct3E)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        regw, memw, br, jmp, jalr, srcb, ill;
    logic [1:0]  rsrc, srca;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic        ctrl_only;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_err    = 0;

  function automatic exp_t z();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input exp_t e, input string t);
    chk({t, ".RegWriteE"},   32'(RegWriteE),   32'(e.regw));
    chk({t, ".MemWriteE"},   32'(MemWriteE),   32'(e.memw));
    chk({t, ".BranchE"},     32'(BranchE),     32'(e.br));
    chk({t, ".JumpE"},       32'(JumpE),       32'(e.jmp));
    chk({t, ".JalrE"},       32'(JalrE),       32'(e.jalr));
    chk({t, ".ALUSrcBE"},    32'(ALUSrcBE),    32'(e.srcb));
    chk({t, ".IllegalE"},    32'(IllegalE),    32'(e.ill));
    chk({t, ".ResultSrcE"},  32'(ResultSrcE),  32'(e.rsrc));
    chk({t, ".ALUSrcAE"},    32'(ALUSrcAE),    32'(e.srca));
    chk({t, ".ALUControlE"}, 32'(ALUControlE), 32'(e.alu));
    if (!e.ctrl_only) begin
      chk({t, ".RD1E"},     RD1E,     e.rd1);
      chk({t, ".RD2E"},     RD2E,     e.rd2);
      chk({t, ".ImmExtE"},  ImmExtE,  e.imm);
      chk({t, ".PCE"},      PCE,      e.pc);
      chk({t, ".PCplus4E"}, PCplus4E, e.pc4);
      chk({t, ".Rs1E"},     32'(Rs1E),    32'(e.rs1));
      chk({t, ".Rs2E"},     32'(Rs2E),    32'(e.rs2));
      chk({t, ".RdE"},      32'(RdE),     32'(e.rd));
      chk({t, ".Funct3E"},  32'(Funct3E), 32'(e.f3));
    end
  endtask

  // Called just after a posedge: drive, push expectation, capture on next edge, pop and compare.
  task automatic step(input logic [31:0] instr, input logic [31:0] pc, input exp_t e_in,
                      input string tag);
    exp_t e;
    e = e_in;
    if (!clr) begin
      e.pc  = pc;
      e.pc4 = pc + 32'd4;
    end
    InstrD = instr; PCD = pc; PCplus4D = pc + 32'd4;
    #1;
    if (!e.ctrl_only && !clr) begin
      chk({tag, ".Rs1D"}, 32'(Rs1D), 32'(e.rs1));
      chk({tag, ".Rs2D"}, 32'(Rs2D), 32'(e.rs2));
    end
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    cmp(sb_q.pop_front(), tag_q.pop_front());
  endtask

  exp_t       e;
  logic [4:0] ra, rb;

  initial begin
    reset = 1'b1; clr = 1'b0;
    InstrD = 32'h005283B3; PCD = 32'h40; PCplus4D = 32'h44;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    #1;
    cmp(z(), "reset0");
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // add x7,x5,x5 with x5 written back in the same cycle
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEADBEEF;
    e = z(); e.rd1 = 32'hDEADBEEF; e.rd2 = 32'hDEADBEEF; e.rs1 = 5; e.rs2 = 5; e.rd = 7;
    e.regw = 1;
    step(32'h005283B3, 32'h100, e, "add_wt");
    RegWriteW = 1'b0;

    // sub x8,x5,x0
    e = z(); e.rd1 = 32'hDEADBEEF; e.rs1 = 5; e.rd = 8; e.regw = 1; e.alu = 4'b0001;
    step(32'h40028433, 32'h104, e, "sub");

    // x0 write with addi x1,x0,-1
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h1234;
    e = z(); e.imm = 32'hFFFFFFFF; e.rs2 = 31; e.rd = 1; e.regw = 1; e.srcb = 1;
    step(32'hFFF00093, 32'h108, e, "addi_x0");
    RegWriteW = 1'b0;

    // add x9,x0,x0 after the x0 write-back
    e = z(); e.rd = 9; e.regw = 1;
    step(32'h000004B3, 32'h10C, e, "x0_read");

    // srai x10,x5,3
    e = z(); e.rd1 = 32'hDEADBEEF; e.imm = 32'h00000403; e.rs1 = 5; e.rs2 = 3; e.rd = 10;
    e.regw = 1; e.srcb = 1; e.alu = 4'b1001; e.f3 = 3'd5;
    step(32'h4032D513, 32'h110, e, "srai");

    // addi x11,x5,-1024 : bit 30 set but must stay ADD
    e = z(); e.rd1 = 32'hDEADBEEF; e.imm = 32'hFFFFFC00; e.rs1 = 5; e.rd = 11;
    e.regw = 1; e.srcb = 1;
    step(32'hC0028593, 32'h114, e, "addi_neg");

    // xor x12,x5,x5
    e = z(); e.rd1 = 32'hDEADBEEF; e.rd2 = 32'hDEADBEEF; e.rs1 = 5; e.rs2 = 5; e.rd = 12;
    e.regw = 1; e.alu = 4'b0100; e.f3 = 3'd4;
    step(32'h0052C633, 32'h118, e, "xor");

    // beq x1,x2,-4
    e = z(); e.imm = 32'hFFFFFFFC; e.rs1 = 1; e.rs2 = 2; e.rd = 29; e.br = 1; e.alu = 4'b0001;
    step(32'hFE208EE3, 32'h11C, e, "beq");

    // jal x1,0x800
    e = z(); e.imm = 32'h00000800; e.rs2 = 1; e.rd = 1; e.regw = 1; e.jmp = 1; e.rsrc = 2'b10;
    step(32'h001000EF, 32'h120, e, "jal");

    // lui x3,0xABCDE
    e = z(); e.imm = 32'hABCDE000; e.rs1 = 27; e.rs2 = 28; e.rd = 3; e.f3 = 3'd6;
    e.regw = 1; e.srca = 2'b10; e.srcb = 1;
    step(32'hABCDE1B7, 32'h124, e, "lui");

    // auipc x4,1
    e = z(); e.imm = 32'h00001000; e.rd = 4; e.f3 = 3'd1; e.regw = 1; e.srca = 2'b01; e.srcb = 1;
    step(32'h00001217, 32'h128, e, "auipc");

    // lw x13,8(x5)
    e = z(); e.rd1 = 32'hDEADBEEF; e.imm = 32'h8; e.rs1 = 5; e.rs2 = 8; e.rd = 13; e.f3 = 3'd2;
    e.regw = 1; e.rsrc = 2'b01; e.srcb = 1;
    step(32'h0082A683, 32'h12C, e, "lw");

    // jalr x1,4(x5)
    e = z(); e.rd1 = 32'hDEADBEEF; e.imm = 32'h4; e.rs1 = 5; e.rs2 = 4; e.rd = 1;
    e.regw = 1; e.jmp = 1; e.jalr = 1; e.rsrc = 2'b10; e.srcb = 1;
    step(32'h004280E7, 32'h130, e, "jalr");

    // flush over sw x5,12(x2), with a write to x6 in the same cycle
    clr = 1'b1; RegWriteW = 1'b1; RdW = 5'd6; ResultW = 32'h0BADF00D;
    step(32'h00512623, 32'h134, z(), "flush_sw");
    clr = 1'b0; RegWriteW = 1'b0;

    // sw x6,12(x2) captured normally, reading the x6 written during the flush
    e = z(); e.rd2 = 32'h0BADF00D; e.imm = 32'hC; e.rs1 = 2; e.rs2 = 6; e.rd = 12; e.f3 = 3'd2;
    e.memw = 1; e.srcb = 1;
    step(32'h00612623, 32'h138, e, "sw_after");

    e = z(); e.ill = 1; e.ctrl_only = 1;
    step(32'hFFFFFFFF, 32'h13C, e, "illegal");
    e = z(); e.ctrl_only = 1;
    step(32'h00000000, 32'h140, e, "bubble");

    // Populate x1 and x31, then read them back
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h11111111;
    step(32'h00000000, 32'h144, z(), "wr_x1");
    RdW = 5'd31; ResultW = 32'h31313131;
    step(32'h00000000, 32'h148, z(), "wr_x31");
    RegWriteW = 1'b0;
    e = z(); e.rd1 = 32'h11111111; e.rd2 = 32'h31313131; e.rs1 = 1; e.rs2 = 31; e.rd = 7;
    e.regw = 1;
    step(32'h01F083B3, 32'h14C, e, "rd_x1_x31");

    // Reset between edges clears outputs at once and drops an in-flight write
    #2 reset = 1'b1;
    #1 cmp(z(), "reset_mid");
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h55;
    @(posedge clk); #1;
    reset = 1'b0; RegWriteW = 1'b0;

    for (int i = 1; i < 32; i += 2) begin
      ra = 5'(i);
      rb = 5'((i + 1) % 32);
      e = z(); e.rs1 = ra; e.rs2 = rb; e.regw = 1;
      step({7'b0, rb, ra, 3'b000, 5'b0, 7'b0110011}, 32'h200 + 32'(i * 4), e, "rst_read");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #20000;
    n_err++;
    $display("FAIL timeout: got running want finished");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the 5-stage RV32I pipeline, directly downstream of the IF/ID register. It takes the latched fetch bundle (InstrD, PCD, PCplus4D) and decodes it. It reads the 32x32 register file, which holds the write-back port, and generates the sign-extended immediate and control word. Its output bundle is registered into the ID/EX register feeding Execute, and it exports Rs1D/Rs2D to the hazard unit.

## Interface
- No parameters. XLEN fixed at 32, 32 architectural registers.
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears the register file and the ID/EX register.
- clr  in  1  synchronous flush of ID/EX from the hazard unit (load-use stall or taken branch/jump).
- InstrD, PCD, PCplus4D  in  32 each  from the IF/ID register.
- RegWriteW  in  1  write-back enable.
- RdW  in  5  write-back destination.
- ResultW  in  32  write-back data.
- Rs1D, Rs2D  out  5 each  combinational InstrD[19:15] and InstrD[24:20], to the hazard unit.
- RD1E, RD2E, ImmExtE, PCE, PCplus4E  out  32 each  registered.
- Rs1E, Rs2E, RdE  out  5 each  registered.
- RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcBE, IllegalE  out  1 each  registered.
- ResultSrcE  out  2  registered: 00 ALU, 01 memory, 10 PC+4.
- ALUSrcAE  out  2  registered: 00 RD1, 01 PC, 10 zero.
- ALUControlE  out  4  registered: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
- Funct3E  out  3  registered InstrD[14:12], for branch condition and load/store width.

## Operation
- Register file:
  - x0 reads 0 always; writes to x0 are ignored.
  - Write at posedge clk when RegWriteW=1 and RdW!=0.
  - Reads are combinational with internal write-through: if RegWriteW and RdW==rsN and rsN!=0, RDN=ResultW this cycle.
- Immediates (sign-extended from bit 31):
  - I: InstrD[31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - U: {[31:12],12'b0}.
- Decode by opcode:
  - 0110011 R: RegWrite, ALUSrcB=0, ALU op from funct3 plus funct7[5]; SUB and SRA when funct7[5]=1.
  - 0010011 I-ALU: RegWrite, ALUSrcB=1, I-imm. funct7[5] is honoured only for funct3=101 (SRAI); ADDI never maps to SUB.
  - 0000011 load: RegWrite, ResultSrc=01, ADD, I-imm.
  - 0100011 store: MemWrite, ADD, S-imm.
  - 1100011 branch: Branch, SUB, B-imm.
  - 1101111 jal: RegWrite, Jump, ResultSrc=10, J-imm.
  - 1100111 jalr: RegWrite, Jump, Jalr, ResultSrc=10, ADD, ALUSrcB=1, I-imm.
  - 0110111 lui: RegWrite, ALUSrcA=10, ALUSrcB=1, U-imm.
  - 0010111 auipc: RegWrite, ALUSrcA=01, ALUSrcB=1, U-imm.
- Unsupported opcode, including the all-zero bubble from the IF/ID register:
  - For any nonzero instruction: all control bits 0 and IllegalE=1.
  - For InstrD==0: IllegalE=0, since this is a legitimate bubble.
- ID/EX priority: reset (async) > clr > capture. There is no enable; stalls are handled upstream by holding IF/ID and flushing here.

## Timing
- Latency: InstrD to the E outputs is one posedge. Rs1D/Rs2D are zero-latency.
- Reset (async, immediate, independent of clk):
  - All E outputs are 0 (ResultSrcE=00, ALUSrcAE=00, ALUControlE=ADD).
  - All 32 registers are 0.
  - Reset asserted mid-operation discards an in-flight write.
- clr=1 at a posedge: all E outputs become 0 (a NOP bubble). The register-file write in the same cycle still occurs.
- Write and read of the same register in the same cycle: the reader sees the new value, so no extra stall is required for a W-to-D hazard.
- A write-back to x0 followed by a read of x0 returns 0.

## Test plan
- Reset: assert reset between edges -> E outputs are 0 at once; reading x1..x31 afterwards returns 0.
- Write-through: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF with InstrD=add x7,x5,x5 -> next edge RD1E=RD2E=0xDEADBEEF, RdE=7, RegWriteE=1, ALUControlE=0000.
- x0 protection: write RdW=0 with ResultW=0x1234, then addi x1,x0,-1 -> RD1E=0, ImmExtE=0xFFFFFFFF, ALUSrcBE=1.
- Immediates:
  - beq with B-imm -4 -> ImmExtE=0xFFFFFFFC, BranchE=1.
  - jal with imm 0x800 -> ImmExtE=0x00000800, JumpE=1, ResultSrcE=10.
  - lui 0xABCDE -> ImmExtE=0xABCDE000, ALUSrcAE=10.
- Flush: clr=1 while InstrD=sw -> MemWriteE=0 and all E outputs 0. The next edge with clr=0 captures the following instruction normally.
- Illegal: InstrD=0xFFFFFFFF -> IllegalE=1, all control bits 0. InstrD=0 -> IllegalE=0, all controls 0.
